// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle control FSM for the ARM datapath.
//   FETCH -> RFETCH -> EXEC -> MEM -> WB, with a sticky FAULT on data-memory timeout.
//   Stage enables, memory request and write gates are decoded combinationally from
//   the state; the condition result is latched in EXEC and gates every write in WB.
// Optional build macro: SKIP_MEM_STAGE_EN -- when defined, instructions that make no
//   memory access (not LDR/STR, or condition failed) go straight from EXEC to WB.
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,  // MEM cycles with an unanswered request before FAULT (1..255)
    parameter int CNT_W       = 16   // retired-instruction counter width
) (
    input  logic             clk,
    input  logic             nreset,     // synchronous, active-high
    input  logic             halt,
    input  logic             is_ldst,
    input  logic             is_branch,
    input  logic             writes_rd,
    input  logic             set_flags,
    input  logic             cond_pass,
    input  logic             mem_ack,
    output logic             fetch_en,
    output logic             rfetch_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             mem_req,
    output logic             reg_we,
    output logic             cpsr_we,
    output logic             pc_inc,
    output logic             pc_branch,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        RFETCH = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd5
    } stateT;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    stateT      curState;
    stateT      nextState;
    logic       condQ;          // condition result captured in EXEC
    logic [7:0] memTimer;       // unanswered request cycles so far in MEM
    logic [7:0] memTimerNext;

    assign state = curState;

    // State, condition latch, memory timer and retired counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (nreset) begin
            curState <= FETCH;
            condQ    <= 1'b0;
            memTimer <= 8'd0;
            retired  <= '0;
        end else begin
            curState <= nextState;
            memTimer <= memTimerNext;
            if (curState == EXEC) begin
                condQ <= cond_pass;
            end
            if (curState == WB) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state decode and per-state outputs; everything forced low while in reset.
    // NOTE: every output gets a default before the case so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState    = curState;
        memTimerNext = 8'd0;
        fetch_en     = 1'b0;
        rfetch_en    = 1'b0;
        exec_en      = 1'b0;
        mem_en       = 1'b0;
        wb_en        = 1'b0;
        mem_req      = 1'b0;
        reg_we       = 1'b0;
        cpsr_we      = 1'b0;
        pc_inc       = 1'b0;
        pc_branch    = 1'b0;
        fault        = 1'b0;

        case (curState)
            FETCH: begin
                if (!halt) begin
                    fetch_en  = 1'b1;
                    nextState = RFETCH;
                end
            end
            RFETCH: begin
                rfetch_en = 1'b1;
                nextState = EXEC;
            end
            EXEC: begin
                exec_en = 1'b1;
`ifdef SKIP_MEM_STAGE_EN
                if (!is_ldst || !cond_pass) begin
                    nextState = WB;
                end else begin
                    nextState = MEM;
                end
`else
                nextState = MEM;
`endif
            end
            MEM: begin
                mem_req = is_ldst & condQ;
                if (!mem_req || mem_ack) begin
                    // Exit cycle: no access needed, or the memory answered (even on
                    // the cycle the timer would otherwise expire).
                    mem_en    = 1'b1;
                    nextState = WB;
                end else if (memTimer == TIMEOUT_LAST) begin
                    nextState = FAULT;
                end else begin
                    memTimerNext = memTimer + 8'd1;
                end
            end
            WB: begin
                wb_en     = 1'b1;
                // Plain rd writes and BL link writes both need a passed condition.
                reg_we    = (condQ & writes_rd & ~is_branch) | (condQ & is_branch & writes_rd);
                cpsr_we   = condQ & set_flags & ~is_ldst;
                pc_branch = condQ & is_branch;
                pc_inc    = ~(condQ & is_branch);
                nextState = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                // Unused codes recover to FETCH.
                nextState = FETCH;
            end
        endcase

        if (nreset) begin
            fetch_en  = 1'b0;
            rfetch_en = 1'b0;
            exec_en   = 1'b0;
            mem_en    = 1'b0;
            wb_en     = 1'b0;
            mem_req   = 1'b0;
            reg_we    = 1'b0;
            cpsr_we   = 1'b0;
            pc_inc    = 1'b0;
            pc_branch = 1'b0;
            fault     = 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed bench for stage_sequencer.
// A second instance with a 3-bit retired counter shares all inputs to show wrap-around.
module tb_stage_sequencer;

    logic clk = 1'b0;
    logic nreset, halt, is_ldst, is_branch, writes_rd, set_flags, cond_pass, mem_ack;
    logic fetch_en, rfetch_en, exec_en, mem_en, wb_en;
    logic mem_req, reg_we, cpsr_we, pc_inc, pc_branch, fault;
    logic [2:0]  state;
    logic [15:0] retired;

    logic w2_fetch_en, w2_rfetch_en, w2_exec_en, w2_mem_en, w2_wb_en;
    logic w2_mem_req, w2_reg_we, w2_cpsr_we, w2_pc_inc, w2_pc_branch, w2_fault;
    logic [2:0] w2_state;
    logic [2:0] w2_retired;

    int tests = 0;
    int fails = 0;

    logic [4:0] en;   // {fetch, rfetch, exec, mem, wb}
    logic [5:0] ctl;  // {mem_req, reg_we, cpsr_we, pc_inc, pc_branch, fault}
    assign en  = {fetch_en, rfetch_en, exec_en, mem_en, wb_en};
    assign ctl = {mem_req, reg_we, cpsr_we, pc_inc, pc_branch, fault};

    always #5 clk = ~clk;

    stage_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .nreset(nreset), .halt(halt), .is_ldst(is_ldst), .is_branch(is_branch),
        .writes_rd(writes_rd), .set_flags(set_flags), .cond_pass(cond_pass), .mem_ack(mem_ack),
        .fetch_en(fetch_en), .rfetch_en(rfetch_en), .exec_en(exec_en), .mem_en(mem_en),
        .wb_en(wb_en), .mem_req(mem_req), .reg_we(reg_we), .cpsr_we(cpsr_we),
        .pc_inc(pc_inc), .pc_branch(pc_branch), .fault(fault), .state(state), .retired(retired)
    );

    stage_sequencer #(.MEM_TIMEOUT(15), .CNT_W(3)) dut_w2 (
        .clk(clk), .nreset(nreset), .halt(halt), .is_ldst(is_ldst), .is_branch(is_branch),
        .writes_rd(writes_rd), .set_flags(set_flags), .cond_pass(cond_pass), .mem_ack(mem_ack),
        .fetch_en(w2_fetch_en), .rfetch_en(w2_rfetch_en), .exec_en(w2_exec_en),
        .mem_en(w2_mem_en), .wb_en(w2_wb_en), .mem_req(w2_mem_req), .reg_we(w2_reg_we),
        .cpsr_we(w2_cpsr_we), .pc_inc(w2_pc_inc), .pc_branch(w2_pc_branch), .fault(w2_fault),
        .state(w2_state), .retired(w2_retired)
    );

    // One clock: outputs are sampled 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge; on return the DUT sits in FETCH (cycle 1 of an instruction).
    task automatic apply_reset();
        nreset = 1'b1;
        step();
        nreset = 1'b0;
        #1;
    endtask

    // Advance until wb_en is high; ok=0 if the cycle budget runs out.
    task automatic run_to_wb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wb_en === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic set_instr(input logic ldst, input logic br, input logic wrd,
                             input logic sf, input logic cp);
        is_ldst = ldst; is_branch = br; writes_rd = wrd; set_flags = sf; cond_pass = cp;
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        step();
        step();
        tests++;
        if (en !== 5'b0) begin
            fails++; $display("FAIL reset_en: got %b expected %b", en, 5'b0);
        end
        tests++;
        if (ctl !== 6'b0) begin
            fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b0);
        end
        tests++;
        if (state !== 3'd0 || retired !== 16'd0) begin
            fails++; $display("FAIL reset_state: got state=%0d retired=%0d expected 0/0", state, retired);
        end
        nreset = 1'b0;
    endtask

    task automatic test_alu();
        logic [4:0] expEn [5];
        logic [5:0] expCtl;
        int n;
        set_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef SKIP_MEM_STAGE_EN
        expEn = '{5'b10000, 5'b01000, 5'b00100, 5'b00001, 5'b00000};
        n = 4;
`else
        expEn = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        n = 5;
`endif
        apply_reset();
        for (int c = 0; c < n; c++) begin
            expCtl = (c == n - 1) ? 6'b011100 : 6'b000000;
            tests++;
            if (en !== expEn[c]) begin
                fails++; $display("FAIL alu_en_cycle%0d: got %b expected %b", c + 1, en, expEn[c]);
            end
            tests++;
            if (ctl !== expCtl) begin
                fails++; $display("FAIL alu_ctl_cycle%0d: got %b expected %b", c + 1, ctl, expCtl);
            end
            step();
        end
        tests++;
        if (retired !== 16'd1 || state !== 3'd0) begin
            fails++; $display("FAIL alu_retired: got retired=%0d state=%0d expected 1/0", retired, state);
        end
    endtask

    task automatic test_ldr_ack();
        int reqCycles;
        set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        mem_ack = 1'b0;
        apply_reset();
        step(); step(); step();          // now cycle 4, first MEM cycle
        reqCycles = 0;
        for (int c = 4; c <= 6; c++) begin
            if (c == 6) begin
                mem_ack = 1'b1;
                #1;
            end
            if (mem_req === 1'b1) reqCycles++;
            tests++;
            if (en !== ((c == 6) ? 5'b00010 : 5'b00000)) begin
                fails++; $display("FAIL ldr_mem_en_cycle%0d: got %b expected %b", c, en,
                                  (c == 6) ? 5'b00010 : 5'b00000);
            end
            step();
        end
        mem_ack = 1'b0;
        tests++;
        if (reqCycles != 3) begin
            fails++; $display("FAIL ldr_req_cycles: got %0d expected 3", reqCycles);
        end
        tests++;
        if (state !== 3'd4 || en !== 5'b00001 || ctl !== 6'b010100) begin
            fails++; $display("FAIL ldr_wb_cycle7: got state=%0d en=%b ctl=%b expected 4/00001/010100",
                              state, en, ctl);
        end
    endtask

    task automatic test_timeout();
        int reqCycles;
        set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        mem_ack = 1'b0;
        apply_reset();
        step(); step(); step();
        reqCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (state === 3'd5) break;
            if (mem_req === 1'b1) reqCycles++;
            step();
        end
        tests++;
        if (reqCycles != 15) begin
            fails++; $display("FAIL timeout_req_cycles: got %0d expected 15", reqCycles);
        end
        step(); step(); step();
        tests++;
        if (state !== 3'd5 || fault !== 1'b1 || en !== 5'b0 || ctl !== 6'b000001) begin
            fails++; $display("FAIL timeout_fault_hold: got state=%0d fault=%b en=%b ctl=%b expected 5/1/00000/000001",
                              state, fault, en, ctl);
        end
        nreset = 1'b1;
        step();
        tests++;
        if (state !== 3'd0 || fault !== 1'b0) begin
            fails++; $display("FAIL timeout_reset: got state=%0d fault=%b expected 0/0", state, fault);
        end
        nreset = 1'b0;
    endtask

    task automatic test_branch();
        bit ok;
        logic [5:0] expCtl [3];
        expCtl = '{6'b000010, 6'b010010, 6'b000100};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: set_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);  // B taken
                1: set_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);  // BL taken
                default: set_instr(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // BL, condition fails
            endcase
            run_to_wb(ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL branch%0d_reach_wb: got timeout expected wb_en", k);
            end
            tests++;
            if (ctl !== expCtl[k]) begin
                fails++; $display("FAIL branch%0d_ctl: got %b expected %b", k, ctl, expCtl[k]);
            end
            step();
            tests++;
            if (retired !== 16'(k + 1)) begin
                fails++; $display("FAIL branch%0d_retired: got %0d expected %0d", k, retired, k + 1);
            end
        end
    endtask

    task automatic test_halt();
        set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        mem_ack = 1'b0;
        halt = 1'b1;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (state !== 3'd0 || en !== 5'b0) begin
                fails++; $display("FAIL halt_cycle%0d: got state=%0d en=%b expected 0/00000", c, state, en);
            end
            step();
        end
        halt = 1'b0;
        #1;
        tests++;
        if (en !== 5'b10000) begin
            fails++; $display("FAIL halt_release_en: got %b expected 10000", en);
        end
        step();
        tests++;
        if (state !== 3'd1) begin
            fails++; $display("FAIL halt_release_state: got %0d expected 1", state);
        end
        step(); step();
        tests++;
        if (state !== 3'd3 || mem_req !== 1'b1) begin
            fails++; $display("FAIL mid_mem: got state=%0d mem_req=%b expected 3/1", state, mem_req);
        end
        nreset = 1'b1;
        step();
        tests++;
        if (state !== 3'd0 || en !== 5'b0 || mem_req !== 1'b0) begin
            fails++; $display("FAIL reset_in_mem: got state=%0d en=%b mem_req=%b expected 0/00000/0",
                              state, en, mem_req);
        end
        nreset = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            run_to_wb(ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL wrap%0d_reach_wb: got timeout expected wb_en", k);
            end
            step();
            if (k == 7) begin
                tests++;
                if (w2_retired !== 3'd7) begin
                    fails++; $display("FAIL wrap_before: got %0d expected 7", w2_retired);
                end
            end
        end
        tests++;
        if (w2_retired !== 3'd0 || retired !== 16'd8) begin
            fails++; $display("FAIL wrap_after: got narrow=%0d wide=%0d expected 0/8", w2_retired, retired);
        end
    endtask

    initial begin
        nreset = 1'b1; halt = 1'b0; mem_ack = 1'b0;
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_alu();
        test_ldr_ack();
        test_timeout();
        test_branch();
        test_halt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
